mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 4-bit 4:1 data mux.
- Four requesters compete for one output channel with valid/ready handshakes.
- The block locks the winner's select for a whole burst, up to the `last` beat or `MAX_BURST` beats, then rotates priority.
- It sits between the requester ports and the downstream consumer, and drives the mux select.

---
 rtl/mux_arb_pkg.sv | 29 ++
 rtl/Mux4to1.sv | 22 ++
 rtl/mux4_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types, widths and the round-robin pick used by the 4:1 mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 4;

  // First requester with valid set, scanning ptr, ptr+1, ... wrapping at N_REQ.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + 2'(i);
      if (!found && valid[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/Mux4to1.sv
// Plain 4-bit 4:1 data mux shared by the requester channels.
module Mux4to1 (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [1:0] s,
  output logic [3:0] y
);

  always_comb begin
    y = d0;
    case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter for four valid/ready requesters sharing one mux output.
//   state  | meaning
//   IDLE   | no grant; pick next requester by rotating priority
//   LOCKED | sel/grant frozen on one requester until last beat or MAX_BURST beats
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [3:0]  req_last,
  input  logic [15:0] req_data,
  output logic [3:0]  req_ready,
  output logic        out_valid,
  output logic [3:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [1:0]  sel,
  output logic [3:0]  grant,
  output logic        busy
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  arb_state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic       locked;
  logic       xfer;
  logic [1:0] pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      sel_q      <= 2'd0;
      grant_q    <= 4'b0000;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign locked = (state_q == LOCKED);
  assign pick   = rr_pick(req_valid, ptr_q);
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          sel_d      = pick;
          grant_d    = 4'b0001 << pick;
          beat_cnt_d = 4'd0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (out_last || (beat_cnt_q == LAST_BEAT)) begin
            ptr_d   = sel_q + 2'd1;
            grant_d = 4'b0000;
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // grant_q is one-hot on sel while locked and zero in IDLE, so it gates ready directly.
  assign req_ready = grant_q & {4{out_ready}};
  assign out_valid = locked & req_valid[sel_q];
  assign out_last  = locked & req_last[sel_q];
  assign sel       = sel_q;
  assign grant     = grant_q;
  assign busy      = locked;

  Mux4to1 u_data_mux (
    .d0 (req_data[3:0]),
    .d1 (req_data[7:4]),
    .d2 (req_data[11:8]),
    .d3 (req_data[15:12]),
    .s  (sel_q),
    .y  (out_data)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized bench for mux4_rr_arbiter against a transaction-level model.
module tb_mux4_rr_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic        out_valid, out_last, out_ready, busy;
  logic [3:0]  out_data;
  logic [1:0]  sel;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: who owns the channel, how many beats it has moved, where priority starts
  int m_locked, m_owner, m_ptr, m_beats, m_xfer;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .grant(grant), .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_xfer = 0;
  endfunction

  task automatic compare_outputs(input string tag);
    logic [3:0] e_grant, e_ready;
    e_grant = m_locked ? 4'(1 << m_owner) : 4'b0000;
    e_ready = (m_locked && out_ready) ? 4'(1 << m_owner) : 4'b0000;
    chk({tag, ".grant"}, 16'(grant), 16'(e_grant));
    chk({tag, ".sel"}, 16'(sel), 16'(m_owner));
    chk({tag, ".busy"}, 16'(busy), 16'(m_locked));
    chk({tag, ".req_ready"}, 16'(req_ready), 16'(e_ready));
    chk({tag, ".out_valid"}, 16'(out_valid), 16'(m_locked != 0 && req_valid[m_owner]));
    chk({tag, ".out_last"}, 16'(out_last), 16'(m_locked != 0 && req_last[m_owner]));
    chk({tag, ".out_data"}, 16'(out_data), 16'(req_data[m_owner*4 +: 4]));
  endtask

  // Applies the spec's per-edge rules to the model using the inputs present at the edge.
  function automatic void model_step();
    m_xfer = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_locked) begin
      if (req_valid != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (req_valid[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            break;
          end
        end
        m_locked = 1;
        m_beats  = 0;
      end
    end else if (req_valid[m_owner] && out_ready) begin
      m_xfer = 1;
      if (req_last[m_owner] || m_beats == MAXB - 1) begin
        m_ptr    = (m_owner + 1) % 4;
        m_locked = 0;
      end else begin
        m_beats++;
      end
    end
  endfunction

  task automatic cycle(input string tag, input logic [3:0] v, input logic [3:0] l,
                       input logic [15:0] d, input logic r);
    req_valid = v; req_last = l; req_data = d; out_ready = r;
    #3;
    compare_outputs(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  int sent, guard, rises;
  logic [3:0] prev_grant;
  logic [1:0] rdy_pat [4];

  initial begin
    rdy_pat[0] = 2'd1; rdy_pat[1] = 2'd0; rdy_pat[2] = 2'd0; rdy_pat[3] = 2'd1;
    model_reset();
    rst_n = 1'b0; req_valid = 4'b1111; req_last = 4'b0000; req_data = 16'h3210; out_ready = 1'b1;
    #2;
    chk("rst.grant", 16'(grant), 16'h0);
    chk("rst.req_ready", 16'(req_ready), 16'h0);
    chk("rst.out_valid", 16'(out_valid), 16'h0);
    chk("rst.sel", 16'(sel), 16'h0);
    chk("rst.out_data", 16'(out_data), 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("rst_rel", 4'b1111, 4'b1111, 16'h3210, 1'b0);
    chk("rst_rel.grant0", 16'(grant), 16'h1);
    cycle("rst_rel_x", 4'b0001, 4'b0001, 16'h3210, 1'b1);
    cycle("drain", 4'b0000, 4'b0000, 16'h0000, 1'b0);

    // single burst from requester 2: A, B, C with last on C
    cycle("sb_arb", 4'b0100, 4'b0000, 16'h0A00, 1'b1);
    cycle("sb_b0", 4'b0100, 4'b0000, 16'h0A00, 1'b1);
    cycle("sb_b1", 4'b0100, 4'b0000, 16'h0B00, 1'b1);
    req_valid = 4'b0100; req_last = 4'b0100; req_data = 16'h0C00; #1;
    chk("sb.out_data_C", 16'(out_data), 16'hC);
    #1;
    cycle("sb_b2", 4'b0100, 4'b0100, 16'h0C00, 1'b1);
    chk("sb.grant_off", 16'(grant), 16'h0);
    cycle("sb_ptr3", 4'b1111, 4'b0000, 16'h0000, 1'b0);
    chk("sb.ptr3_grant", 16'(grant), 16'h8);
    cycle("sb_end", 4'b1000, 4'b1000, 16'h0000, 1'b1);

    // rotation with single-beat bursts from everyone
    for (int i = 0; i < 10; i++) cycle("rot", 4'b1111, 4'b1111, 16'h7654, 1'b1);
    cycle("drain", 4'b0000, 4'b0000, 16'h0000, 1'b1);

    // forced release: requester 1, 12 beats, last only on the 12th
    sent = 0; guard = 0; rises = 0; prev_grant = grant;
    while (sent < 12 && guard < 40) begin
      cycle("force", 4'b0010, (sent == 11) ? 4'b0010 : 4'b0000, 16'(sent << 4), 1'b1);
      if (m_xfer != 0) sent++;
      if (grant == 4'b0010 && prev_grant != 4'b0010) rises++;
      prev_grant = grant;
      guard++;
    end
    chk("force.beats", 16'(sent), 16'd12);
    chk("force.regrants", 16'(rises), 16'd2);
    cycle("drain", 4'b0000, 4'b0000, 16'h0000, 1'b1);

    // backpressure and valid gaps on requester 3
    sent = 0; guard = 0;
    while (sent < 4 && guard < 40) begin
      cycle("bp", (guard >= 3 && guard < 5) ? 4'b0000 : 4'b1000,
            (sent == 3) ? 4'b1000 : 4'b0000, 16'(sent << 12), rdy_pat[guard % 4][0]);
      if (m_xfer != 0) sent++;
      guard++;
    end
    chk("bp.beats", 16'(sent), 16'd4);
    cycle("drain", 4'b0000, 4'b0000, 16'h0000, 1'b1);

    // reset mid-burst after beat 2 of 5
    sent = 0;
    cycle("rm_arb", 4'b0100, 4'b0000, 16'h0500, 1'b1);
    cycle("rm_b0", 4'b0100, 4'b0000, 16'h0500, 1'b1);
    cycle("rm_b1", 4'b0100, 4'b0000, 16'h0600, 1'b1);
    rst_n = 1'b0; #1;
    model_reset();
    compare_outputs("rm_async");
    chk("rm.grant", 16'(grant), 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("rm_rearb", 4'b1111, 4'b0000, 16'h0000, 1'b0);
    chk("rm.grant0", 16'(grant), 16'h1);
    cycle("rm_end", 4'b0001, 4'b0001, 16'h0000, 1'b1);

    // randomized traffic; second half never asserts last so bursts hit the beat limit
    for (int i = 0; i < 2400; i++) begin
      logic [3:0] v, l;
      for (int b = 0; b < 4; b++) begin
        v[b] = ($urandom_range(0, 3) != 0);
        l[b] = (i < 1200) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      cycle("rnd", v, l, 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
